door_sensor_conditioner: RTL

Front-end stage feeding the automatic door controller: it turns the raw, asynchronous, bouncy door-sensor and switch signals into clean, synchronous inputs for the controller. Every input is synchronised and debounced. The person-approach signal is stretched so the door does not start closing on a momentary sensor dropout. Manual-open attempts become single-cycle pulses, so the controller counts exactly one attempt per press. The limit switches are checked for inconsistency, and a sticky fault flag forces an obstruction indication so the door holds open.

---
 rtl/door_sensor_conditioner.sv | 99 +++++++++
 1 files changed

// File: rtl/door_sensor_conditioner.sv
// Conditions raw door sensors and switches: 2-flop sync, debounce, approach stretch, manual-open pulse, limit-switch fault.
// All outputs are registered; the mo pulse and pa/pp are computed from next-state debounced values so they align with the debounced edges.
module door_sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int FAULT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pa_raw,
  input  logic pp_raw,
  input  logic mo_raw,
  input  logic lk_raw,
  input  logic r_raw,
  input  logic m_raw,
  input  logic l_raw,
  input  logic fault_clr,
  output logic pa,
  output logic pp,
  output logic mo,
  output logic lk,
  output logic r,
  output logic m,
  output logic l,
  output logic lim_fault
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int FW = $clog2(FAULT_CYCLES + 1);
  // Bit order: pa, pp, mo, lk, r, m, l. Middle limit resets high (doors closed).
  localparam logic [6:0] RST_VAL = 7'b010_0000;

  logic [6:0] raw, s1, s2, deb, deb_nxt;
  logic [DW-1:0] cnt [7];
  logic [DW-1:0] cnt_nxt [7];
  logic [HW-1:0] hold, hold_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          cond, flt_nxt;

  assign raw = {l_raw, m_raw, r_raw, lk_raw, mo_raw, pp_raw, pa_raw};

  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < 7; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != deb[i]) begin
        if (cnt[i] == DW'(DEB_CYCLES - 1)) deb_nxt[i] = s2[i];
        else                               cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    hold_nxt = '0;
    if (deb_nxt[0])       hold_nxt = '0;
    else if (deb[0])      hold_nxt = HW'(HOLD_CYCLES);
    else if (hold != '0)  hold_nxt = hold - 1'b1;
  end

  // Fault logic looks at the registered debounced limits; set has priority over clear.
  assign cond = deb[5] & (deb[4] | deb[6]);

  always_comb begin
    fcnt_nxt = '0;
    if (cond) fcnt_nxt = (fcnt == FW'(FAULT_CYCLES)) ? fcnt : fcnt + 1'b1;
    flt_nxt = (fcnt_nxt == FW'(FAULT_CYCLES)) | (lim_fault & ~(fault_clr & ~cond));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= RST_VAL;
      s2        <= RST_VAL;
      deb       <= RST_VAL;
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
      hold      <= '0;
      fcnt      <= '0;
      lim_fault <= 1'b0;
      pa        <= 1'b0;
      pp        <= 1'b0;
      mo        <= 1'b0;
    end else begin
      s1        <= raw;
      s2        <= s1;
      deb       <= deb_nxt;
      for (int i = 0; i < 7; i++) cnt[i] <= cnt_nxt[i];
      hold      <= hold_nxt;
      fcnt      <= fcnt_nxt;
      lim_fault <= flt_nxt;
      pa        <= deb_nxt[0] | (hold_nxt != '0);
      pp        <= deb_nxt[1] | flt_nxt;
      mo        <= deb_nxt[2] & ~deb[2];
    end
  end

  assign lk = deb[3];
  assign r  = deb[4];
  assign m  = deb[5];
  assign l  = deb[6];
endmodule
